firebird7_in_gate1_ijtag_sib_access_ctrl: RTL and testbench
===========================================================

Name: firebird7_in_gate1_ijtag_sib_access_ctrl

Overview:
Host-side IJTAG sequencer for one spare SIB with a SEG_LEN-bit instrument segment behind it, running on the ijtag_tck domain. A single request opens the SIB if it is closed, then runs one capture-shift-update (CSU) access over the SIB plus the segment. It returns the captured segment data and optionally closes the SIB. Lets gate1 firmware and test logic reach spare instruments without hand-building CSU sequences.

Parameters:
SEG_LEN, 8, number of scan bits in the segment behind the SIB (1..64)
SETTLE_CYC, 2, idle cycles after each update so the SIB's two negedge stages (latch, to_sel) propagate
CNT_W, $clog2(SEG_LEN+2), width of the shift counter (derived; do not override)

Ports:
ijtag_tck  in  1  sole clock; all logic on posedge
ijtag_reset  in  1  synchronous, active-high reset
req_valid  in  1  access request
req_ready  out  1  high only in IDLE
req_keep_open  in  1  1: leave the SIB open after the access; 0: close it
req_wr_data  in  SEG_LEN  data to shift into the segment
rsp_valid  out  1  response available; held until rsp_ready
rsp_ready  in  1  response consumed
rsp_rd_data  out  SEG_LEN  segment data captured during the access
rsp_err  out  1  chain-integrity failure seen during this request
sib_open  out  1  controller's tracked SIB state
ijtag_sel  out  1  network select; high only during CE/SE/UE cycles
ijtag_ce  out  1  capture enable
ijtag_se  out  1  shift enable
ijtag_ue  out  1  update enable
ijtag_si  out  1  scan data to the SIB
ijtag_so  in  1  retimed scan output from the SIB

Behaviour:
- All outputs are registered. Reset value of every output is 0, except req_ready, which goes to 1 on the first cycle after reset deasserts. Reset clears the state to IDLE and sib_open to 0. The SIB network shares this reset domain, so after reset the SIB is treated as closed.
- Reset asserted mid-operation: the sequence is abandoned, sel/ce/se/ue go low on the next edge, and any pending response is dropped.
- A request is accepted when req_valid and req_ready are both high in the same cycle. The controller latches req_wr_data and req_keep_open, and req_ready drops on the next cycle.
- States: IDLE, OPEN_CAP, OPEN_SH, OPEN_UPD, OPEN_SETTLE, ACC_CAP, ACC_SH, ACC_UPD, ACC_SETTLE, RESP.
- From IDLE on accept, go to OPEN_CAP if sib_open=0, otherwise to ACC_CAP.
- Open phase:
  - OPEN_CAP: sel=1, ce=1 for one cycle.
  - OPEN_SH: sel=1, se=1 for one cycle, si=1. Sample so at this posedge; it must be 0, otherwise set rsp_err.
  - OPEN_UPD: sel=1, ue=1 for one cycle.
  - OPEN_SETTLE: SETTLE_CYC cycles with sel=0. On exit set sib_open=1.
- Access phase:
  - ACC_CAP: sel=1, ce=1 for one cycle.
  - ACC_SH: sel=1, se=1 for SEG_LEN+1 cycles, shift index k=0..SEG_LEN.
  - At k=0: si=req_keep_open. so is sampled as the SIB's capture value; it must be 0, otherwise set rsp_err.
  - At k=1..SEG_LEN: si=wr_data[SEG_LEN-k] (MSB first), and so is sampled into rd_data[SEG_LEN-k].
  - ACC_UPD: sel=1, ue=1 for one cycle.
  - ACC_SETTLE: SETTLE_CYC cycles. On exit sib_open=req_keep_open.
- RESP: rsp_valid=1 with rd_data and err stable. On rsp_valid & rsp_ready, go to IDLE, and req_ready=1 on the following cycle.
- ce, se and ue are mutually exclusive, and sel is never high with all three low.
- Latency (SEG_LEN=8, SETTLE_CYC=2, accept at cycle 0):
  - SIB closed: rsp_valid first high at cycle 19.
  - SIB open: rsp_valid first high at cycle 14.
  - General cases: 2*SETTLE_CYC+SEG_LEN+7 (closed) and SETTLE_CYC+SEG_LEN+4 (open).
- Shift counter counts 0..SEG_LEN and is cleared on entry to ACC_SH. The counter must not wrap.
- rsp_err is sticky per request and cleared on accept.

Decomposition:
- Package firebird7_in_gate1_ijtag_ctrl_pkg holds:
  - the state enum state_e;
  - CSU phase constants;
  - a function returning the access latency for given SEG_LEN/SETTLE_CYC, for bench use.
- One sub-module, firebird7_in_gate1_ijtag_csu_seq:
  - generic single-CSU engine with a length input, a serial si source and a serial so sink, plus settle wait;
  - instantiated once and reused for the open and access phases;
  - the top block holds the request/response FSM and sib_open tracking.

Test Plan:
- Reset, then request wr_data=8'hA5, keep_open=1, with the SIB model's segment holding 8'h3C.
  - Expected: the open CSU, then the access CSU.
  - rsp_valid at cycle 19, rd_data=8'h3C, err=0, sib_open=1, segment holds 8'hA5.
- With the SIB already open, request wr_data=8'h5A, keep_open=0.
  - Expected: no open phase, rsp_valid at cycle 14, rd_data=8'hA5, sib_open=0.
  - The model's ijtag_to_sel is low after the settle cycles.
- Force ijtag_so=1 throughout a request.
  - Expected: rsp_err=1, rd_data=8'hFF, and the FSM still completes and returns to IDLE.
- Assert ijtag_reset during ACC_SH at k=4.
  - Expected: outputs 0 on the next edge, sib_open=0, no rsp_valid; the next request runs the open phase.
- Hold rsp_ready=0 for 5 cycles.
  - Expected: rsp_valid and data stay stable, req_ready stays 0, and req_valid pulses are ignored.
- Send back-to-back requests.
  - Expected: req_ready returns 1 exactly one cycle after the response handshake.
  - Assertions: ce/se/ue one-hot-or-zero, and sel=0 in IDLE/SETTLE/RESP.

Source files
------------

// File: rtl/firebird7_in_gate1_ijtag_ctrl_pkg.sv
// Shared types for the gate1 IJTAG SIB access controller: request FSM states,
// CSU engine phases and the expected access latency.
package firebird7_in_gate1_ijtag_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE, OPEN_CAP, OPEN_SH, OPEN_UPD, OPEN_SETTLE,
      ACC_CAP, ACC_SH, ACC_UPD, ACC_SETTLE, RESP
   } state_e;

   typedef enum logic [2:0] {
      PH_IDLE, PH_CAP, PH_SH, PH_UPD, PH_SETTLE
   } csu_phase_e;

   // Cycles from accept to first rsp_valid.
   function automatic int access_latency(input int seg_len, input int settle_cyc,
                                         input bit sib_closed);
      return sib_closed ? 2*settle_cyc + seg_len + 7 : settle_cyc + seg_len + 4;
   endfunction

endpackage

// File: rtl/firebird7_in_gate1_ijtag_csu_seq.sv
// Single capture-shift-update engine: shifts len+1 bits from si_data (bit 0 first),
// collects so into so_data[k], then idles SETTLE_CYC cycles with sel low.
module firebird7_in_gate1_ijtag_csu_seq
   import firebird7_in_gate1_ijtag_ctrl_pkg::*;
#(
   parameter int SEG_LEN    = 8,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   len,
   input  logic [SEG_LEN:0]   si_data,
   output logic [SEG_LEN:0]   so_data,
   output logic               last,
   output logic               sel,
   output logic               ce,
   output logic               se,
   output logic               ue,
   output logic               si,
   input  logic               so
);

   localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   csu_phase_e       phase;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] len_q;
   logic [ST_W-1:0]  st_cnt;
   logic [SEG_LEN:0] sh;

   always_comb begin
      case (phase)
         PH_SH:     last = (cnt == len_q);
         PH_SETTLE: last = (st_cnt == ST_W'(SETTLE_CYC - 1));
         default:   last = 1'b1;
      endcase
   end

   // start wins over the phase walk so a new CSU can chain directly off a settle exit.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase   <= PH_IDLE;
         cnt     <= '0;
         len_q   <= '0;
         st_cnt  <= '0;
         sh      <= '0;
         so_data <= '0;
         sel     <= 1'b0;
         ce      <= 1'b0;
         se      <= 1'b0;
         ue      <= 1'b0;
         si      <= 1'b0;
      end else if (start) begin
         phase   <= PH_CAP;
         len_q   <= len;
         sh      <= si_data;
         so_data <= '0;
         sel     <= 1'b1;
         ce      <= 1'b1;
         se      <= 1'b0;
         ue      <= 1'b0;
         si      <= 1'b0;
      end else begin
         case (phase)
            PH_CAP: begin
               phase <= PH_SH;
               ce    <= 1'b0;
               se    <= 1'b1;
               si    <= sh[0];
               sh    <= sh >> 1;
               cnt   <= '0;
            end
            PH_SH: begin
               for (int i = 0; i <= SEG_LEN; i++)
                  if (cnt == CNT_W'(i)) so_data[i] <= so;
               if (last) begin
                  phase <= PH_UPD;
                  se    <= 1'b0;
                  ue    <= 1'b1;
                  si    <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
                  si  <= sh[0];
                  sh  <= sh >> 1;
               end
            end
            PH_UPD: begin
               phase  <= PH_SETTLE;
               sel    <= 1'b0;
               ue     <= 1'b0;
               st_cnt <= '0;
            end
            PH_SETTLE: begin
               if (last) phase  <= PH_IDLE;
               else      st_cnt <= st_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/firebird7_in_gate1_ijtag_sib_access_ctrl.sv
// Request/response front end for one spare SIB: opens the SIB if needed, runs one
// access CSU over SIB + segment, returns captured data and tracks SIB state.
module firebird7_in_gate1_ijtag_sib_access_ctrl
   import firebird7_in_gate1_ijtag_ctrl_pkg::*;
#(
   parameter int SEG_LEN    = 8,
   parameter int SETTLE_CYC = 2
) (
   input  logic               ijtag_tck,
   input  logic               ijtag_reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_keep_open,
   input  logic [SEG_LEN-1:0] req_wr_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [SEG_LEN-1:0] rsp_rd_data,
   output logic               rsp_err,
   output logic               sib_open,
   output logic               ijtag_sel,
   output logic               ijtag_ce,
   output logic               ijtag_se,
   output logic               ijtag_ue,
   output logic               ijtag_si,
   input  logic               ijtag_so
);

   localparam int CNT_W = $clog2(SEG_LEN + 2);

   state_e             state;
   logic [SEG_LEN-1:0] wr_q;
   logic               keep_q;
   logic               accept, open_phase, seq_start, seq_last;
   logic [SEG_LEN-1:0] acc_wr, rd_bits;
   logic               acc_keep;
   logic [SEG_LEN:0]   acc_data, seq_data, so_data;
   logic [CNT_W-1:0]   seq_len;

   assign accept     = req_valid & req_ready;
   assign open_phase = (state == IDLE) && !sib_open;
   // Access data comes straight off the request when the SIB is already open.
   assign acc_wr     = (state == IDLE) ? req_wr_data   : wr_q;
   assign acc_keep   = (state == IDLE) ? req_keep_open : keep_q;
   assign seq_start  = ((state == IDLE) && accept) || ((state == OPEN_SETTLE) && seq_last);
   assign seq_len    = open_phase ? '0 : CNT_W'(SEG_LEN);
   assign seq_data   = open_phase ? {{SEG_LEN{1'b0}}, 1'b1} : acc_data;

   // SIB bit shifts first, then the segment MSB first.
   always_comb begin
      acc_data    = '0;
      rd_bits     = '0;
      acc_data[0] = acc_keep;
      for (int k = 1; k <= SEG_LEN; k++) acc_data[k] = acc_wr[SEG_LEN-k];
      for (int i = 0; i < SEG_LEN; i++)  rd_bits[i]  = so_data[SEG_LEN-i];
   end

   firebird7_in_gate1_ijtag_csu_seq #(
      .SEG_LEN(SEG_LEN), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)
   ) u_csu (
      .clk(ijtag_tck), .rst(ijtag_reset), .start(seq_start), .len(seq_len),
      .si_data(seq_data), .so_data(so_data), .last(seq_last),
      .sel(ijtag_sel), .ce(ijtag_ce), .se(ijtag_se), .ue(ijtag_ue),
      .si(ijtag_si), .so(ijtag_so)
   );

   always_ff @(posedge ijtag_tck) begin
      if (ijtag_reset) begin
         state       <= IDLE;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rd_data <= '0;
         rsp_err     <= 1'b0;
         sib_open    <= 1'b0;
         wr_q        <= '0;
         keep_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  wr_q      <= req_wr_data;
                  keep_q    <= req_keep_open;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b0;
                  state     <= sib_open ? ACC_CAP : OPEN_CAP;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            OPEN_CAP: state <= OPEN_SH;
            OPEN_SH:  if (seq_last) state <= OPEN_UPD;
            OPEN_UPD: state <= OPEN_SETTLE;
            OPEN_SETTLE: begin
               if (seq_last) begin
                  state    <= ACC_CAP;
                  sib_open <= 1'b1;
                  rsp_err  <= rsp_err | so_data[0];
               end
            end
            ACC_CAP:  state <= ACC_SH;
            ACC_SH:   if (seq_last) state <= ACC_UPD;
            ACC_UPD:  state <= ACC_SETTLE;
            ACC_SETTLE: begin
               if (seq_last) begin
                  state       <= RESP;
                  sib_open    <= keep_q;
                  rsp_valid   <= 1'b1;
                  rsp_rd_data <= rd_bits;
                  rsp_err     <= rsp_err | so_data[0];
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_firebird7_in_gate1_ijtag_sib_access_ctrl.sv
// Directed bench for the SIB access controller with a behavioural SIB + 8-bit segment model.
module tb_firebird7_in_gate1_ijtag_sib_access_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0, req_ready, req_keep_open = 1'b0;
   logic [7:0] req_wr_data = '0;
   logic       rsp_valid, rsp_ready = 1'b1, rsp_err, sib_open;
   logic [7:0] rsp_rd_data;
   logic       sel, ce, se, ue, si, so;
   logic       force_so = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   firebird7_in_gate1_ijtag_sib_access_ctrl #(.SEG_LEN(8), .SETTLE_CYC(2)) dut (
      .ijtag_tck(clk), .ijtag_reset(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_keep_open(req_keep_open),
      .req_wr_data(req_wr_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err), .sib_open(sib_open),
      .ijtag_sel(sel), .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue),
      .ijtag_si(si), .ijtag_so(so)
   );

   // SIB model: scan path si -> seg[0..7] -> sib bit -> so (retimed on negedge).
   logic       sib_sr, sib_latch, to_sel, so_r;
   logic [7:0] seg_sr, seg_upd;

   assign so = force_so ? 1'b1 : so_r;

   always @(posedge clk) begin
      if (rst) begin
         sib_sr <= 1'b0;
         seg_sr <= '0;
      end else if (sel && ce) begin
         sib_sr <= 1'b0;
         if (to_sel) seg_sr <= seg_upd;
      end else if (sel && se) begin
         if (to_sel) begin
            seg_sr <= {seg_sr[6:0], si};
            sib_sr <= seg_sr[7];
         end else begin
            sib_sr <= si;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         sib_latch <= 1'b0;
         to_sel    <= 1'b0;
         so_r      <= 1'b0;
         seg_upd   <= 8'h3C;
      end else begin
         so_r   <= sib_sr;
         to_sel <= sib_latch;
         if (sel && ue) begin
            sib_latch <= sib_sr;
            if (to_sel) seg_upd <= seg_sr;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Enable discipline every cycle.
   always @(negedge clk) begin
      chk("en_onehot0", 32'($countones({ce, se, ue}) <= 1), 32'd1);
      chk("sel_iff_en", 32'(sel), 32'(ce | se | ue));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Waits for ready, issues one request, returns cycles from accept to rsp_valid.
   task automatic run_req(input logic [7:0] wr, input logic keep, output int lat);
      int n;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      req_wr_data   = wr;
      req_keep_open = keep;
      req_valid     = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
   endtask

   typedef struct {
      logic [7:0] wr;
      logic       keep;
      logic       fso;
      int         lat;
      logic [7:0] rd;
      logic       err;
      logic       open;
      logic       tosel;
      logic [7:0] seg;
   } vec_t;

   vec_t vecs[4];
   int   lat;

   initial begin
      vecs[0] = '{wr:8'hA5, keep:1'b1, fso:1'b0, lat:19, rd:8'h3C, err:1'b0, open:1'b1, tosel:1'b1, seg:8'hA5};
      vecs[1] = '{wr:8'h5A, keep:1'b0, fso:1'b0, lat:14, rd:8'hA5, err:1'b0, open:1'b0, tosel:1'b0, seg:8'h5A};
      vecs[2] = '{wr:8'h0F, keep:1'b1, fso:1'b1, lat:19, rd:8'hFF, err:1'b1, open:1'b1, tosel:1'b1, seg:8'h0F};
      vecs[3] = '{wr:8'h96, keep:1'b1, fso:1'b0, lat:14, rd:8'h0F, err:1'b0, open:1'b1, tosel:1'b1, seg:8'h96};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outs", 32'({req_ready, rsp_valid, rsp_err, sib_open, sel, ce, se, ue, si}), 32'd0);
      chk("reset_rd", 32'(rsp_rd_data), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(req_ready), 32'd1);
      chk("open_after_reset", 32'(sib_open), 32'd0);

      for (int i = 0; i < 4; i++) begin
         force_so = vecs[i].fso;
         run_req(vecs[i].wr, vecs[i].keep, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_rd", i), 32'(rsp_rd_data), 32'(vecs[i].rd));
         chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].err));
         chk($sformatf("v%0d_sib_open", i), 32'(sib_open), 32'(vecs[i].open));
         chk($sformatf("v%0d_to_sel", i), 32'(to_sel), 32'(vecs[i].tosel));
         chk($sformatf("v%0d_seg", i), 32'(seg_upd), 32'(vecs[i].seg));
         @(negedge clk);
         force_so = 1'b0;
         chk($sformatf("v%0d_ready_next", i), 32'({req_ready, rsp_valid}), 32'b10);
      end

      // Reset during ACC_SH at k=4 (SIB open: ACC_CAP is cycle 1, k=0 cycle 2).
      req_wr_data = 8'hC3; req_keep_open = 1'b1; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (lat < 6) begin @(negedge clk); lat++; end
      chk("mid_shift_se", 32'({sel, se}), 32'b11);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_reset_outs", 32'({sel, ce, se, ue, rsp_valid, sib_open, req_ready}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_mid_reset", 32'(req_ready), 32'd1);
      run_req(8'h11, 1'b1, lat);
      chk("post_reset_latency", 32'(lat), 32'd19);
      chk("post_reset_rd", 32'(rsp_rd_data), 32'h3C);
      chk("post_reset_err", 32'(rsp_err), 32'd0);
      @(negedge clk);

      // Response back-pressure: everything holds, req_valid pulses ignored.
      rsp_ready = 1'b0;
      run_req(8'h22, 1'b1, lat);
      chk("hold_latency", 32'(lat), 32'd14);
      for (int i = 0; i < 5; i++) begin
         req_valid = i[0];
         @(negedge clk);
         chk($sformatf("hold%0d_state", i), 32'({rsp_valid, req_ready, sel}), 32'b100);
         chk($sformatf("hold%0d_rd", i), 32'(rsp_rd_data), 32'h11);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_release", 32'({req_ready, rsp_valid}), 32'b10);

      // Back-to-back with req_valid held high.
      req_wr_data = 8'h33; req_keep_open = 1'b1; req_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready_drop", 32'(req_ready), 32'd0);
      req_wr_data = 8'h44; req_keep_open = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
      chk("b2b1_latency", 32'(lat), 32'd14);
      chk("b2b1_rd", 32'(rsp_rd_data), 32'h22);
      @(negedge clk);
      chk("b2b_ready_one_after", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b2_accepted", 32'(req_ready), 32'd0);
      lat = 1;
      while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
      chk("b2b2_latency", 32'(lat), 32'd14);
      chk("b2b2_rd", 32'(rsp_rd_data), 32'h33);
      chk("b2b2_sib_open", 32'(sib_open), 32'd0);
      repeat (4) @(negedge clk);
      chk("b2b2_to_sel", 32'(to_sel), 32'd0);
      chk("b2b2_seg", 32'(seg_upd), 32'h44);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
